// File: rtl/demoscene_pkg.sv
// Shared constants, FSM state type and register map for the demoscene SPI
// control block.
package demoscene_pkg;

    localparam int SPI_FRAME_BITS = 16;
    localparam int SPI_CMD_BITS   = 8;
    localparam int SPI_W_BIT      = 15;

    // Register map seen by the pixel, PWM and audio consumers.
    localparam int REG_COLOR      = 0;
    localparam int REG_SAMPLE     = 1;
    localparam int REG_AUDIO_CTRL = 2;
    localparam int REG_SCROLL     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } spi_state_e;

    // A 7-bit frame address is usable only when the bits above the decoded
    // field are zero and it names an implemented register.
    function automatic logic addr_in_range(input logic [6:0] addr,
                                           input int num_regs,
                                           input int addr_w);
        int a;
        a = int'(addr);
        return ((a >> addr_w) == 32'sd0) && (a < num_regs);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, plus single-clk rise and
// fall pulses taken from a registered copy of the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain and one-clk-delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_ctrl_regs.sv
// SPI mode-0 slave, oversampled in the clk domain, owning the control
// register file. Frame: W, A[6:0], D[7:0], MSB first.
module spi_ctrl_regs
    import demoscene_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int ADDR_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  SSEL,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [NUM_REGS*8-1:0] regs,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr
);

    localparam int W_IDX = SPI_W_BIT - SPI_CMD_BITS;

    logic sclk_sync_unused_s, sclk_rise_s, sclk_fall_s;
    logic ssel_sync_s, ssel_rise_unused_s, ssel_fall_s;
    logic mosi_sync_s, mosi_rise_unused_s, mosi_fall_unused_s;

    spi_state_e state_q, state_d;

    logic [4:0]            cnt_q;
    logic [7:0]            shift_in_q;
    logic [7:0]            cmd_q;
    logic [7:0]            shift_out_q;
    logic                  commit_q;
    logic                  miso_q;
    logic [NUM_REGS*8-1:0] regs_q;
    logic                  wr_strobe_q;
    logic [ADDR_W-1:0]     wr_addr_q;

    logic                  shift_en_s, cmd_last_s, frame_last_s, miso_shift_s;
    logic [7:0]            cmd_next_s;
    logic [ADDR_W-1:0]     rd_idx_s, wr_idx_s;
    logic [7:0]            rd_byte_s, rd_load_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .async_i(SCLK),
        .sync_o(sclk_sync_unused_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_ssel_sync (
        .clk(clk), .rst_n(rst_n), .async_i(SSEL),
        .sync_o(ssel_sync_s), .rise_o(ssel_rise_unused_s), .fall_o(ssel_fall_s)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_mosi_sync (
        .clk(clk), .rst_n(rst_n), .async_i(MOSI),
        .sync_o(mosi_sync_s), .rise_o(mosi_rise_unused_s), .fall_o(mosi_fall_unused_s)
    );

    // The byte the shift-in register would hold after the current rise;
    // at the 8th rise it is the command byte.
    assign cmd_next_s = {shift_in_q[6:0], mosi_sync_s};
    assign rd_idx_s   = cmd_next_s[ADDR_W-1:0];
    assign wr_idx_s   = cmd_q[ADDR_W-1:0];
    assign rd_byte_s  = regs_q[{rd_idx_s, 3'b000} +: 8];
    assign rd_load_s  = addr_in_range(cmd_next_s[6:0], NUM_REGS, ADDR_W) ? rd_byte_s : 8'h00;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: select released always aborts to IDLE.
    always_comb begin
        state_d = state_q;
        if (ssel_sync_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = ssel_fall_s  ? CMD  : IDLE;
                CMD:     state_d = cmd_last_s   ? DATA : CMD;
                DATA:    state_d = frame_last_s ? DONE : DATA;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs: shift, command-latch, frame-end and MISO-shift enables.
    always_comb begin
        shift_en_s   = 1'b0;
        cmd_last_s   = 1'b0;
        frame_last_s = 1'b0;
        miso_shift_s = 1'b0;
        if (!ssel_sync_s) begin
            case (state_q)
                CMD: begin
                    shift_en_s = sclk_rise_s;
                    cmd_last_s = sclk_rise_s && (cnt_q == 5'(SPI_CMD_BITS - 1));
                end
                DATA: begin
                    shift_en_s   = sclk_rise_s;
                    frame_last_s = sclk_rise_s && (cnt_q == 5'(SPI_FRAME_BITS - 1));
                    miso_shift_s = sclk_fall_s && !cmd_q[W_IDX];
                end
                default: begin
                    shift_en_s   = 1'b0;
                    cmd_last_s   = 1'b0;
                    frame_last_s = 1'b0;
                    miso_shift_s = 1'b0;
                end
            endcase
        end else begin
            shift_en_s   = 1'b0;
            cmd_last_s   = 1'b0;
            frame_last_s = 1'b0;
            miso_shift_s = 1'b0;
        end
    end

    // Bit counter, shift-in/out registers, command latch and commit request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= 5'd0;
            shift_in_q  <= 8'h00;
            cmd_q       <= 8'h00;
            shift_out_q <= 8'h00;
            commit_q    <= 1'b0;
        end else begin
            commit_q <= frame_last_s && cmd_q[W_IDX]
                        && addr_in_range(cmd_q[6:0], NUM_REGS, ADDR_W);
            if (state_d == IDLE) begin
                cnt_q <= 5'd0;
            end else if (shift_en_s) begin
                cnt_q <= cnt_q + 5'd1;
            end
            if (shift_en_s) begin
                shift_in_q <= cmd_next_s;
            end
            // Read data is captured at the 8th rise, before any later write.
            if (cmd_last_s) begin
                cmd_q       <= cmd_next_s;
                shift_out_q <= cmd_next_s[W_IDX] ? 8'h00 : rd_load_s;
            end else if (miso_shift_s) begin
                shift_out_q <= {shift_out_q[6:0], 1'b0};
            end
        end
    end

    // MISO: one bit per fall in a read DATA phase, forced low otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
        end else if ((state_d != DATA) || cmd_q[W_IDX]) begin
            miso_q <= 1'b0;
        end else if (miso_shift_s) begin
            miso_q <= shift_out_q[7];
        end
    end

    // Register file write commit, one-clk strobe and last-written address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            wr_strobe_q <= commit_q;
            if (commit_q) begin
                regs_q[{wr_idx_s, 3'b000} +: 8] <= shift_in_q;
                wr_addr_q                       <= wr_idx_s;
            end
        end
    end

    assign MISO      = miso_q;
    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_ctrl_regs.sv
// Scoreboard bench for spi_ctrl_regs: stimulus pushes expected writes and
// read bytes; monitors pop and compare when the DUT strobes or a frame ends.
module tb_spi_ctrl_regs;

    localparam int NREGS = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        SCLK  = 1'b0;
    logic        SSEL  = 1'b1;
    logic        MOSI  = 1'b0;
    logic        MISO;
    logic [63:0] regs;
    logic        wr_strobe;
    logic [2:0]  wr_addr;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    logic [7:0] ref_mem [NREGS];

    typedef struct {
        logic [2:0]  addr;
        logic [63:0] snap;
    } wr_exp_t;

    wr_exp_t    wr_q[$];
    logic [7:0] rd_q[$];

    int         mon_cnt  = 0;
    logic       mon_w    = 1'b0;
    logic [7:0] mon_byte = 8'h00;

    always #5 clk = ~clk;

    spi_ctrl_regs dut (
        .clk(clk), .rst_n(rst_n), .SCLK(SCLK), .SSEL(SSEL), .MOSI(MOSI),
        .MISO(MISO), .regs(regs), .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    function automatic logic [63:0] model_flat();
        logic [63:0] v;
        for (int i = 0; i < NREGS; i++) v[i*8 +: 8] = ref_mem[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && wr_strobe) begin
            strobe_cnt++;
            if (wr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got strobe at addr %0d expected none", wr_addr);
            end else begin
                wr_exp_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk("regs_after_write", regs, e.snap);
            end
        end
    end

    // Read monitor: follows the pins, collects MISO on data-phase rises.
    always @(posedge SCLK or negedge SSEL) begin
        if (SCLK == 1'b0) begin
            mon_cnt  = 0;
            mon_w    = 1'b0;
            mon_byte = 8'h00;
        end else if (SSEL == 1'b0) begin
            mon_cnt++;
            if (mon_cnt == 1) mon_w = MOSI;
            if (mon_cnt >= 9 && mon_cnt <= 16) mon_byte = {mon_byte[6:0], MISO};
            if (mon_cnt == 16) begin
                if (mon_w) begin
                    chk("miso_write_frame", 64'(mon_byte), 64'h0);
                end else if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got byte %0h expected no read", mon_byte);
                end else begin
                    chk("miso_read_byte", 64'(mon_byte), 64'(rd_q.pop_front()));
                end
            end
        end
    end

    task automatic spi_xfer(input logic [15:0] frame, input int nrise, input bit do_reset);
        logic       w;
        logic [6:0] a;
        logic [7:0] d;
        w = frame[15];
        a = frame[14:8];
        d = frame[7:0];
        if (nrise >= 16 && !do_reset) begin
            if (w) begin
                if (a < 7'd8) begin
                    ref_mem[a[2:0]] = d;
                    wr_q.push_back('{addr: a[2:0], snap: model_flat()});
                end
            end else begin
                rd_q.push_back((a < 7'd8) ? ref_mem[a[2:0]] : 8'h00);
            end
        end
        @(negedge clk);
        SSEL = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nrise; i++) begin
            MOSI = (i < 16) ? frame[15-i] : 1'($urandom);
            repeat (5) @(negedge clk);
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
        if (do_reset) begin
            #1;
            chk("pre_reset_miso", 64'(MISO), 64'h1);
            rst_n = 1'b0;
            #1;
            chk("reset_mid_regs", regs, 64'h0);
            chk("reset_mid_miso", 64'(MISO), 64'h0);
            chk("reset_mid_strobe", 64'(wr_strobe), 64'h0);
            for (int k = 0; k < NREGS; k++) ref_mem[k] = 8'h00;
            SSEL = 1'b1;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
            SSEL = 1'b1;
            repeat (8) @(negedge clk);
            chk("regs_vs_model", regs, model_flat());
        end
    endtask

    initial begin
        int s0;
        for (int k = 0; k < NREGS; k++) ref_mem[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_regs", regs, 64'h0);
        chk("reset_miso", 64'(MISO), 64'h0);
        chk("reset_strobe", 64'(wr_strobe), 64'h0);
        chk("reset_wr_addr", 64'(wr_addr), 64'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic write W=1 A=1 D=A5.
        s0 = strobe_cnt;
        spi_xfer(16'h81A5, 16, 1'b0);
        chk("reg1_a5", 64'(regs[15:8]), 64'hA5);
        chk("others_zero", regs & 64'hFFFF_FFFF_FFFF_00FF, 64'h0);
        chk("one_strobe_basic", 64'(strobe_cnt - s0), 64'h1);

        // Write then read back 0x3C at address 0.
        spi_xfer(16'h803C, 16, 1'b0);
        spi_xfer({8'h00, 8'($urandom)}, 16, 1'b0);

        // Abort after 12 bits of a write to address 2.
        s0 = strobe_cnt;
        spi_xfer(16'h8277, 12, 1'b0);
        chk("abort_reg2", 64'(regs[23:16]), 64'h0);
        chk("abort_no_strobe", 64'(strobe_cnt - s0), 64'h0);

        // Out-of-range write and read at A=0x09.
        s0 = strobe_cnt;
        spi_xfer(16'h895A, 16, 1'b0);
        spi_xfer(16'h0900, 16, 1'b0);
        chk("oor_no_strobe", 64'(strobe_cnt - s0), 64'h0);

        // 24 rises in one select: single commit of 0x81 to address 3.
        s0 = strobe_cnt;
        spi_xfer(16'h8381, 24, 1'b0);
        chk("long_frame_reg3", 64'(regs[31:24]), 64'h81);
        chk("long_frame_one_strobe", 64'(strobe_cnt - s0), 64'h1);

        // Select without any clock does nothing.
        s0 = strobe_cnt;
        SSEL = 1'b0;
        repeat (50) @(negedge clk);
        SSEL = 1'b1;
        repeat (8) @(negedge clk);
        chk("idle_select_regs", regs, model_flat());
        chk("idle_select_no_strobe", 64'(strobe_cnt - s0), 64'h0);

        // Reset in the middle of a read data phase, then normal traffic.
        spi_xfer(16'h84FF, 16, 1'b0);
        spi_xfer(16'h0400, 12, 1'b1);
        spi_xfer(16'h8655, 16, 1'b0);
        spi_xfer(16'h0600, 16, 1'b0);

        // Randomised frames: mostly legal, some aborted, some overlong.
        for (int n = 0; n < 40; n++) begin
            logic [15:0] f;
            int          sel;
            int          nr;
            f   = 16'($urandom);
            sel = $urandom_range(0, 9);
            if (sel < 6) f[14:8] = 7'($urandom_range(0, 7));
            nr  = (sel == 8) ? $urandom_range(1, 15) : ((sel == 9) ? $urandom_range(17, 24) : 16);
            spi_xfer(f, nr, 1'b0);
        end

        for (int k = 0; k < 100 && (wr_q.size() != 0 || rd_q.size() != 0); k++) @(negedge clk);
        chk("wr_queue_drained", 64'(wr_q.size()), 64'h0);
        chk("rd_queue_drained", 64'(rd_q.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
